lsu_bus_bridge: RTL and testbench

- Load/store unit directly downstream of the pipeline's Memory stage.
- Consumes the M-stage address, store data, and load/store strobes. Drives a request/grant/response word bus toward data memory. Returns load data to the W pipeline register.
- Asserts a stall back to the hazard unit while an access is outstanding, so memory latency is variable instead of fixed single-cycle.
- Also handles misalignment detection and a bus timeout.

---
 rtl/lsu_bus_bridge.sv | 145 ++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the M stage and a req/gnt/rvalid data-memory bus.
// Stalls the pipeline while an access is outstanding; flags misalignment and bus timeouts.
module lsu_bus_bridge #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        TimeoutM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             we_q;

  logic access;
  logic aligned;
  logic expired;

  assign access  = MemReadM | MemWriteM;
  assign aligned = (ALUResultM[1:0] == 2'b00);
  assign expired = (cnt == CNT_W'(TIMEOUT));

  // A grant in the final REQ cycle still wins over the timeout: once the bus
  // has accepted the request it cannot be taken back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees
      // the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (access) begin
            if (!aligned) begin
              rdata_q <= '0;
            end else begin
              addr_q  <= {ALUResultM[31:2], 2'b00};
              wdata_q <= WriteDataM;
              we_q    <= MemWriteM;
              cnt     <= CNT_W'(1);
              if (!bus_gnt)        state <= REQ;
              else if (!MemWriteM) state <= RSP;
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            cnt   <= CNT_W'(1);
            state <= we_q ? IDLE : RSP;
          end else if (expired) begin
            rdata_q <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RSP: begin
          if (bus_rvalid) begin
            rdata_q <= bus_rdata;
            state   <= IDLE;
          end else if (expired) begin
            rdata_q <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are Mealy: a zero-wait store and the rvalid pass-through must act
  // in the same cycle as the bus handshake. Reset forces every output low.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned, which would infer a latch.
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    TimeoutM  = 1'b0;
    ReadDataM = rdata_q;
    if (rst) begin
      case (state)
        IDLE: begin
          if (access) begin
            if (!aligned) begin
              MisalignM = 1'b1;
            end else begin
              bus_req   = 1'b1;
              bus_we    = MemWriteM;
              bus_addr  = {ALUResultM[31:2], 2'b00};
              bus_wdata = WriteDataM;
              StallM    = !(bus_gnt && MemWriteM);
            end
          end
        end
        REQ: begin
          bus_req   = 1'b1;
          bus_we    = we_q;
          bus_addr  = addr_q;
          bus_wdata = wdata_q;
          if (bus_gnt)      StallM   = !we_q;
          else if (expired) TimeoutM = 1'b1;
          else              StallM   = 1'b1;
        end
        RSP: begin
          if (bus_rvalid)   ReadDataM = bus_rdata;
          else if (expired) TimeoutM  = 1'b1;
          else              StallM    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge: directed vector table, hand sequences for reset and
// timeout, then randomized traffic against a transaction-level reference model.
module tb_lsu_bus_bridge;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, TimeoutM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  lsu_bus_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .TimeoutM(TimeoutM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        mis;
    logic        tmo;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        rd, wr;
    logic [31:0] a, d;
    logic        gnt, rv;
    logic [31:0] rdat;
    exp_t        e;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) $display("FAIL %s: got %h, expected %h", name, act, want);
    else              n_pass++;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".req"}, bus_req, e.req);
    if (e.req) begin
      check({tag, ".we"},    bus_we,    e.we);
      check({tag, ".addr"},  bus_addr,  e.addr);
      check({tag, ".wdata"}, bus_wdata, e.wdata);
    end
    check({tag, ".stall"}, StallM,    e.stall);
    check({tag, ".mis"},   MisalignM, e.mis);
    check({tag, ".tmo"},   TimeoutM,  e.tmo);
    check({tag, ".rdata"}, ReadDataM, e.rdata);
    check({tag, ".excl"},  32'(StallM) + 32'(MisalignM) + 32'(TimeoutM) <= 32'd1, 1);
  endtask

  task automatic drive(input logic rd, wr, input logic [31:0] a, d,
                       input logic gnt, rv, input logic [31:0] rdat);
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = d;
    bus_gnt = gnt; bus_rvalid = rv; bus_rdata = rdat;
    #1;
  endtask

  function automatic void add(input logic rd, wr, input logic [31:0] a, d,
                              input logic gnt, rv, input logic [31:0] rdat,
                              input logic req, we, input logic [31:0] ba, bwd,
                              input logic st, mis, tmo, input logic [31:0] rdm);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.gnt = gnt; v.rv = rv; v.rdat = rdat;
    v.e.req = req; v.e.we = we; v.e.addr = ba; v.e.wdata = bwd;
    v.e.stall = st; v.e.mis = mis; v.e.tmo = tmo; v.e.rdata = rdm;
    vq.push_back(v);
  endfunction

  // Reference model: tracks one outstanding transaction (issued, granted or
  // not, cycles waited since its last progress) and the last load result.
  bit          m_pend, m_granted, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_wait;

  task automatic model_reset();
    m_pend = 0; m_granted = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_wait = 0;
  endtask

  task automatic model_cycle(input bit rd, wr, input logic [31:0] a, d,
                             input bit gnt, rv, input logic [31:0] rdat, output exp_t e);
    e = '0;
    e.rdata = m_rdata;
    if (!m_pend) begin
      if (rd || wr) begin
        if (a[1:0] != 2'b00) begin
          e.mis = 1; m_rdata = '0;
        end else begin
          e.req = 1; e.we = wr; e.addr = {a[31:2], 2'b00}; e.wdata = d;
          if (!(gnt && wr)) begin
            e.stall = 1; m_pend = 1; m_granted = gnt; m_we = wr;
            m_addr = {a[31:2], 2'b00}; m_wdata = d; m_wait = 1;
          end
        end
      end
    end else if (!m_granted) begin
      e.req = 1; e.we = m_we; e.addr = m_addr; e.wdata = m_wdata;
      if (gnt) begin
        if (m_we) m_pend = 0;
        else begin e.stall = 1; m_granted = 1; m_wait = 1; end
      end else if (m_wait == TIMEOUT) begin
        e.tmo = 1; m_pend = 0; m_rdata = '0;
      end else begin
        e.stall = 1; m_wait++;
      end
    end else begin
      if (rv) begin
        e.rdata = rdat; m_rdata = rdat; m_pend = 0;
      end else if (m_wait == TIMEOUT) begin
        e.tmo = 1; m_pend = 0; m_rdata = '0;
      end else begin
        e.stall = 1; m_wait++;
      end
    end
  endtask

  initial begin
    exp_t        e;
    exp_t        zero_e;
    int          stalls;
    bit          done;
    bit          hold;
    int          quiet;
    int          kind;
    bit          rd, wr, gnt, rv;
    logic [31:0] a, d, rdat;

    zero_e = '0;

    // Rows: rd wr addr wdata gnt rv rdata | req we baddr bwdata stall mis tmo ReadDataM
    add(0,1,32'h100,32'hCAFEF00D,1,0,0,       1,1,32'h100,32'hCAFEF00D,0,0,0,0);
    add(0,0,0,0,1,0,0,                        0,0,0,0,0,0,0,0);
    add(1,0,32'h204,0,0,0,0,                  1,0,32'h204,0,1,0,0,0);
    add(1,0,32'hFFF0,32'hDEAD,0,0,0,          1,0,32'h204,0,1,0,0,0);
    add(1,0,32'hFFF0,32'hDEAD,1,0,0,          1,0,32'h204,0,1,0,0,0);
    add(1,0,32'h204,0,0,0,0,                  0,0,0,0,1,0,0,0);
    add(1,0,32'h204,0,0,0,0,                  0,0,0,0,1,0,0,0);
    add(1,0,32'h204,0,0,1,32'h12345678,       0,0,0,0,0,0,0,32'h12345678);
    add(0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,32'h12345678);
    add(1,0,32'h203,0,1,0,0,                  0,0,0,0,0,1,0,32'h12345678);
    add(0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0);
    add(0,1,32'h102,32'h1111,1,0,0,           0,0,0,0,0,1,0,0);
    add(0,1,32'h10,32'hAAAA5555,1,0,0,        1,1,32'h10,32'hAAAA5555,0,0,0,0);
    add(1,0,32'h14,0,1,0,0,                   1,0,32'h14,0,1,0,0,0);
    add(1,0,32'h14,0,1,1,32'hBEEF0001,        0,0,0,0,0,0,0,32'hBEEF0001);
    add(0,0,0,0,0,0,0,                        0,0,0,0,0,0,0,32'hBEEF0001);

    // Reset state
    #1;
    check_out("reset", zero_e);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].rd, vq[i].wr, vq[i].a, vq[i].d, vq[i].gnt, vq[i].rv, vq[i].rdat);
      check_out($sformatf("vec%0d", i), vq[i].e);
    end

    // Reset while waiting for rvalid, then a stale rvalid in IDLE
    drive(1,0,32'h80,0,1,0,0);
    drive(1,0,32'h80,0,0,0,0);
    check("rstseq.stall_rsp", StallM, 1);
    @(negedge clk); rst = 1'b0; #1;
    check_out("rstseq.during", zero_e);
    @(negedge clk); rst = 1'b1;
    MemReadM = 0; MemWriteM = 0; ALUResultM = 0; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h55;
    #1;
    check_out("rstseq.stale", zero_e);
    drive(0,1,32'h300,32'h1,1,0,0);
    check("rstseq.idle_store_req", bus_req, 1);
    check("rstseq.idle_store_stall", StallM, 0);

    // Timeout: variant 0 granted then no rvalid, variant 1 never granted
    for (int v = 0; v < 2; v++) begin
      drive(1,0,32'h80,0,1,0,0);
      drive(1,0,32'h80,0,0,1,32'h77);
      check($sformatf("tmo%0d.prime", v), ReadDataM, 32'h77);
      drive(1,0,32'h40,0,(v == 0),0,0);
      check($sformatf("tmo%0d.issue_addr", v), bus_addr, 32'h40);
      stalls = StallM ? 1 : 0;
      done = 0;
      for (int c = 0; c < 3 * TIMEOUT && !done; c++) begin
        drive(1,0,32'h40,0,0,0,0);
        if (TimeoutM) begin
          done = 1;
          check($sformatf("tmo%0d.stall_at_abort", v), StallM, 0);
          check($sformatf("tmo%0d.rdata_at_abort", v), ReadDataM, 32'h77);
        end else if (StallM) begin
          stalls++;
        end
      end
      check($sformatf("tmo%0d.seen", v), done, 1);
      check($sformatf("tmo%0d.stall_cycles", v), stalls, TIMEOUT);
      drive(0,0,0,0,0,1,32'h99);
      check($sformatf("tmo%0d.late_rdata", v), ReadDataM, 0);
      check($sformatf("tmo%0d.late_stall", v), StallM, 0);
      check($sformatf("tmo%0d.late_tmo", v), TimeoutM, 0);
    end

    // Randomized traffic against the model; the pipeline holds M while stalled
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    model_reset();
    hold = 0; quiet = 0;
    rd = 0; wr = 0; a = '0; d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        kind = $urandom_range(0, 9);
        rd = (kind >= 3 && kind <= 5) || kind == 9;
        wr = (kind >= 6);
        a = $urandom & 32'h0000_FFFF;
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        d = $urandom;
      end
      if (quiet > 0) quiet--;
      else if ($urandom_range(0, 199) == 0) quiet = TIMEOUT + 9;
      gnt  = (quiet == 0) && ($urandom_range(0, 99) < 55);
      rv   = (quiet == 0) && ($urandom_range(0, 99) < 40);
      rdat = $urandom;
      drive(rd, wr, a, d, gnt, rv, rdat);
      model_cycle(rd, wr, a, d, gnt, rv, rdat, e);
      check_out($sformatf("rnd%0d", i), e);
      hold = e.stall;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
